// File: rtl/member_scan_pkg.sv
// member_scan_pkg: shared state enum, result bundle and width helpers.
// Ports: none. Used by member_scan, member_scan_if, member_lane_match.
package member_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Upper bounds for the result fields. The top slices out the bits
    // its DEPTH actually needs.
    localparam int MAX_IW = 16;
    localparam int MAX_CW = 17;

    typedef struct packed {
        logic              hit;
        logic [MAX_IW-1:0] idx;
        logic [MAX_CW-1:0] cnt;
    } result_t;

    // Index width for n entries; never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold a count 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/member_scan_if.sv
// member_scan_if: write/clear port, query channel and result channel.
// master drives writes, queries and r_ready; slave is the checker.
interface member_scan_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) ();
    import member_scan_pkg::*;

    localparam int IW = idx_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic             wr_en;
    logic [IW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             wr_vld;
    logic             clr;

    logic             q_valid;
    logic             q_ready;
    logic [WIDTH-1:0] q_value;

    logic             r_valid;
    logic             r_ready;
    logic             r_hit;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_count;

    modport master (
        output wr_en, wr_idx, wr_data, wr_vld, clr,
        output q_valid, q_value, r_ready,
        input  q_ready, r_valid, r_hit, r_idx, r_count
    );

    modport slave (
        input  wr_en, wr_idx, wr_data, wr_vld, clr,
        input  q_valid, q_value, r_ready,
        output q_ready, r_valid, r_hit, r_idx, r_count
    );

endinterface

// File: rtl/member_lane_match.sv
// member_lane_match: compares one beat slice of LANES entries to value.
// In: vld, data, value. Out: any, lane (lowest hit), pop (MEMBER_COUNT_EN).
module member_lane_match
    import member_scan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
`ifdef MEMBER_COUNT_EN
    parameter int PW    = cnt_w(LANES),
`endif
    parameter int LW    = idx_w(LANES)
) (
    input  logic [LANES-1:0]            vld,
    input  logic [LANES-1:0][WIDTH-1:0] data,
    input  logic [WIDTH-1:0]            value,
`ifdef MEMBER_COUNT_EN
    output logic [PW-1:0]               pop,
`endif
    output logic                        any,
    output logic [LW-1:0]               lane
);

    logic [LANES-1:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < LANES; i++) begin
            hit[i] = vld[i] && (data[i] == value);
        end
    end

    assign any = |hit;

    // Walk downwards so the last assignment is the lowest hit.
    always_comb begin
        lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                lane = LW'(i);
            end
        end
    end

`ifdef MEMBER_COUNT_EN
    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + PW'(hit[i]);
        end
    end
`endif

endmodule

// File: rtl/member_scan.sv
// member_scan: DEPTH-entry table, multi-beat membership lookup.
// Ports: clk, rst_n (async low), bus (member_scan_if.slave).
// Macro MEMBER_COUNT_EN: full scan with match count in r_count.
module member_scan
    import member_scan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    member_scan_if.slave bus
);

    localparam int IW     = idx_w(DEPTH);
    localparam int CW     = cnt_w(DEPTH);
    localparam int LW     = idx_w(LANES);
    localparam int NBEATS = DEPTH / LANES;
    localparam int BW     = idx_w(NBEATS);
`ifdef MEMBER_COUNT_EN
    localparam int PW     = cnt_w(LANES);
`endif

    state_e                      state_q, state_d;
    logic [BW-1:0]               beat_q, beat_d;
    logic [WIDTH-1:0]            value_q, value_d;
    result_t                     res_q, res_d;
    logic [DEPTH-1:0]            vld_q, vld_d;
    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;

    logic [LANES-1:0]            sl_vld;
    logic [LANES-1:0][WIDTH-1:0] sl_data;
    logic                        any;
    logic [LW-1:0]               lane;
    logic [IW-1:0]               hit_idx;
    logic                        last;
`ifdef MEMBER_COUNT_EN
    logic [PW-1:0]               pop;
`endif

    // Table write port; clr overrides a same-cycle write.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (bus.clr) begin
            vld_d = '0;
        end else if (bus.wr_en) begin
            vld_d[bus.wr_idx]  = bus.wr_vld;
            data_d[bus.wr_idx] = bus.wr_data;
        end
    end

    // Beat mux: the compare always sees the pre-edge table.
    always_comb begin
        sl_vld  = '0;
        sl_data = '0;
        for (int l = 0; l < LANES; l++) begin
            sl_vld[l]  = vld_q[IW'(int'(beat_q) * LANES + l)];
            sl_data[l] = data_q[IW'(int'(beat_q) * LANES + l)];
        end
    end

    member_lane_match #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_match (
        .vld   (sl_vld),
        .data  (sl_data),
        .value (value_q),
`ifdef MEMBER_COUNT_EN
        .pop   (pop),
`endif
        .any   (any),
        .lane  (lane)
    );

    assign hit_idx = IW'(int'(beat_q) * LANES + int'(lane));
    assign last    = (beat_q == BW'(NBEATS - 1));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        value_d = value_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (bus.q_valid) begin
                    value_d = bus.q_value;
                    beat_d  = '0;
                    res_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
`ifdef MEMBER_COUNT_EN
                // Keep the first (lowest) hit, keep counting.
                if (any && !res_q.hit) begin
                    res_d.hit = 1'b1;
                    res_d.idx = MAX_IW'(hit_idx);
                end
                res_d.cnt = res_q.cnt + MAX_CW'(pop);
                if (last) begin
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
`else
                if (any) begin
                    res_d.hit = 1'b1;
                    res_d.idx = MAX_IW'(hit_idx);
                    state_d   = DONE;
                end else if (last) begin
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
`endif
            end
            DONE: begin
                if (bus.r_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            value_q <= '0;
            res_q   <= '0;
            vld_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            value_q <= value_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
        end
    end

    // Gated by rst_n so no query is accepted while reset is held.
    assign bus.q_ready = rst_n && (state_q == IDLE);
    assign bus.r_valid = (state_q == DONE);
    assign bus.r_hit   = res_q.hit;
    assign bus.r_idx   = res_q.idx[IW-1:0];
`ifdef MEMBER_COUNT_EN
    assign bus.r_count = res_q.cnt[CW-1:0];
`else
    assign bus.r_count = '0;
`endif

    // Upper result bits beyond IW/CW are constant zero.
    logic unused_res;
    assign unused_res = ^{res_q.idx, res_q.cnt};

endmodule

// File: doc/member_scan.md
# member_scan

Parametrised, table-based membership checker. It holds a writable table of DEPTH tagged entries and answers valid/ready queries of the form "is this value in the table, and at which index?". Each cycle it scans LANES entries and stops at the first hit. It is the sequential, multi-lane successor of the team's combinational `inside` checkers, intended for classification and filter paths where table size exceeds what a single-cycle compare can close timing on.

## Interface
- WIDTH, 8, entry and query value width
- DEPTH, 16, table entries; multiple of LANES
- LANES, 4, entries compared per scan beat; power of two, ≤ DEPTH
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write one table entry this cycle
- wr_idx  in  $clog2(DEPTH)  entry index to write
- wr_data  in  WIDTH  entry value
- wr_vld  in  1  entry valid bit to store (0 = delete)
- clr  in  1  invalidate all entries
- q_valid  in  1  query presented
- q_ready  out  1  block can accept a query
- q_value  in  WIDTH  value to look up
- r_valid  out  1  result available
- r_ready  in  1  consumer takes result
- r_hit  out  1  a valid entry equals q_value
- r_idx  out  $clog2(DEPTH)  lowest matching index; 0 on miss
- r_count  out  $clog2(DEPTH+1)  number of matches (MEMBER_COUNT_EN only; 0 otherwise)

## Operation
- NBEATS = DEPTH/LANES. Table = DEPTH × {vld, data}. Reset and clr clear every vld bit; data is don't-care.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: q_ready=1. On q_valid: latch q_value, beat=0, go to SCAN.
  - SCAN: compare entries beat*LANES … beat*LANES+LANES-1 (vld && data==value).
    - Any hit: load r_hit=1, r_idx=lowest hit index, go to DONE.
    - Else on beat==NBEATS-1: load r_hit=0, r_idx=0, go to DONE.
    - Else beat+1.
  - DONE: r_valid=1. On r_ready, go to IDLE.
- q_ready=0 in SCAN and DONE. The query is not re-sampled.
- Writes and clr are accepted in every state and take effect at the edge. A compare in the same cycle sees the old contents. Entries already scanned are not re-checked.
- clr and wr_en in the same cycle: clr wins and the write is dropped.
- Outputs r_hit, r_idx and r_count hold stable while r_valid && !r_ready.

## Timing
- Reset values: q_ready=1 after release, with 0 while rst_n is low. r_valid=0, r_hit=0, r_idx=0, r_count=0, state=IDLE, all vld=0.
- Accept edge E0. A hit in beat k gives r_valid high after edge E(k+1), which is k+1 cycles. A miss gives NBEATS cycles.
- Back-to-back: r_ready is taken in DONE, and the earliest next acceptance is the following cycle (IDLE). Throughput is at most one query per latency+2 cycles.
- Asserting rst_n low mid-scan aborts immediately. No result is produced and the table is cleared.

## Configuration
- MEMBER_COUNT_EN defined:
  - Early exit is disabled; every query takes NBEATS cycles.
  - r_count accumulates per-beat popcounts of matches.
  - r_idx is still the lowest matching index.
- MEMBER_COUNT_EN undefined:
  - Early exit on first hit as described above.
  - r_count tied to 0 and no popcount logic is built.

## Structure
- Package member_scan_pkg holds:
  - the state enum (IDLE/SCAN/DONE);
  - a result struct {hit, idx, count};
  - a localparam function for index/count widths.
- One sub-module, member_lane_match:
  - LANES-wide compare of one beat slice against value;
  - outputs any-hit, lowest-lane index and popcount.
  - Purely combinational, instantiated once; the beat mux feeds it.

## Test plan
Defaults: WIDTH=8, DEPTH=16, LANES=4.
- Write entries 0–7 with i*10 (vld=1), query 30 → r_hit=1, r_idx=3, r_valid 1 cycle after accept. Query 70 → r_idx=7 after 2 cycles.
- Query 25 → r_hit=0, r_idx=0 after 4 cycles. Write idx 5 with wr_vld=0, then query 50 → miss.
- Entries 2 and 9 both =0x55, query 0x55 → r_idx=2.
  - With MEMBER_COUNT_EN: r_count=2, latency 4.
- Hold r_ready=0 for 5 cycles in DONE → r_valid and r_idx stable, q_ready=0, and a new q_valid is ignored until release.
- clr and wr_en (idx 0, 0xAA) in the same cycle, then query 0xAA → miss. Write idx 15 = 0xAA during beat 1 of a query for 0xAA → the scan reaches beat 3 and hits at idx 15.
- Drop rst_n in SCAN beat 1 → r_valid stays 0, q_ready=0 while in reset and 1 after release, all entries invalid (query 0 → miss).
